csa_addsub_pipe: RTL
====================

# csa_addsub_pipe

Parametrised, pipelined carry-select adder/subtractor with valid/ready streaming handshake. Computes A+B or A−B (A + ~B + 1) on WIDTH-bit operands, split across STAGES register stages, each built from BLOCK-bit carry-select cells. It sits in the datapath wherever the 32-bit combinational carry-select add/sub is too slow for the target clock. Sustains one operation per cycle at a fixed latency.

## Interface
- WIDTH, 32, operand and result width.
- BLOCK, 4, bits per carry-select cell.
- STAGES, 2, pipeline depth. WIDTH must be a multiple of STAGES*BLOCK, otherwise elaboration fails with `$error`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- sub_i  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum_o  out  WIDTH  result, modulo 2^WIDTH.
- cout_o  out  1  carry out. For subtraction, 1 means no borrow (A ≥ B unsigned).
- ovf_o  out  1  signed overflow. Present only with the flags build.
- zero_o  out  1  sum_o == 0. Present only with the flags build.

## Operation
- The operand is divided into STAGES slices of W_S = WIDTH/STAGES bits. Stage k adds slice k, using the carry from stage k−1 (stage 0 uses sub_i as carry-in). B is inverted when sub_i = 1.
- Inside a slice, W_S/BLOCK carry-select cells are chained. Each cell precomputes its sum for cin = 0 and cin = 1, and the incoming carry selects one result.
- The stage k register holds:
  - completed low sum bits;
  - the untouched upper slices of A and ~B;
  - the carry;
  - sub and the sign bits needed for the flags;
  - a valid bit.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_valid and the input data must be held stable until accepted.
  - out_valid and the output data are held stable until consumed.
- Stall: stage k advances when its successor is empty or advancing. in_ready = !valid[0] || advance[0]. Bubbles collapse, so a full pipeline with out_ready high accepts and emits in the same cycle.
- Ordering: results emerge in acceptance order. None are dropped or duplicated.

## Timing
- Latency is STAGES cycles from acceptance to out_valid when there is no back-pressure. Throughput is 1 op/cycle.
- Capacity is STAGES results in flight.
- in_ready is combinational from out_ready. No other input-to-output combinational path exists.
- Reset (rst_n low), effective immediately and asynchronously:
  - all valid bits are cleared;
  - sum_o, cout_o, ovf_o and zero_o are set to 0;
  - out_valid is set to 0.
  - in_ready is 1 after reset.
- Reset mid-operation discards in-flight beats. Nothing from before the reset appears after release.
- Wrap-around: 0xFFFFFFFF+1 gives sum 0 and cout 1. There is no saturation.
- With STAGES = 1 the block is a single registered stage with latency 1.

## Configuration
- CSA_FLAGS_EN defined:
  - ovf_o and zero_o ports exist;
  - ovf = (sA == sB') && (sS != sA), where sB' is the sign of the possibly inverted B;
  - both flags are registered alongside sum_o.
- CSA_FLAGS_EN undefined: the ports and the flag logic are absent. All other behaviour is identical.

## Structure
- Package csa_pkg holds:
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - a function checking the WIDTH / STAGES / BLOCK divisibility;
  - the default parameter constants.
- Sub-module csa_cell is a BLOCK-bit carry-select cell with two ripple adders and a result/carry mux. It is instantiated W_S/BLOCK times per stage via generate.
- The top level owns the stage registers, the valid chain and the stall logic.

## Test plan
All scenarios use WIDTH=32, BLOCK=4, STAGES=2, with the flags build unless noted.
- Add 0xFFFFFFFF + 0x00000001 -> sum_o 0x00000000, cout_o 1, zero_o 1, out_valid 2 cycles after acceptance.
- Subtract 5−7 -> 0xFFFFFFFE with cout_o 0. Then 7−5 -> 0x00000002 with cout_o 1, back-to-back on consecutive cycles.
- Overflow cases:
  - 0x7FFFFFFF + 1 -> ovf_o 1;
  - 0x80000000 − 1 -> 0x7FFFFFFF with ovf_o 1;
  - 0x80000000 + 0x80000000 -> 0, cout_o 1, ovf_o 1.
- Back-pressure: hold out_ready low and offer 3 beats. Exactly 2 are accepted, then in_ready goes 0 and out_valid/sum_o stay stable. Raise out_ready: results 1, 2, 3 emerge in order on consecutive cycles.
- Reset: drop rst_n with 2 beats in flight. out_valid goes 0 asynchronously and in_ready is 1 after release. No stale result appears within 5 cycles of idle.
- Random: 1000 random ops with random in_valid/out_ready, compared against a behavioural model (A + (sub ? ~B+1 : B)). Zero mismatches. Throughput is 1/cycle when both valid and ready are held high. Repeat the same run with CSA_FLAGS_EN undefined.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared constants and configuration checks for the pipelined carry-select adder/subtractor.
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_BLOCK  = 4;
    localparam int DEF_STAGES = 2;

    // Every stage must split into a whole number of carry-select cells.
    function automatic bit cfg_ok(input int width, input int stages, input int block);
        if (stages < 1 || block < 1 || width < 1) return 1'b0;
        return (width % (stages * block)) == 0;
    endfunction

endpackage

// File: rtl/csa_addsub_pipe_cell.sv
// BLOCK-bit carry-select cell: two ripple adders (carry-in 0 and 1) and a carry-driven select.
module csa_cell
    import csa_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;
    logic [BLOCK:0]   c0;
    logic [BLOCK:0]   c1;

    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = cin ? s1 : s0;
    assign cout = cin ? c1[BLOCK] : c0[BLOCK];

endmodule

// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select add/sub with valid/ready stall chain; one WIDTH/STAGES slice per stage.
// Define CSA_FLAGS_EN to add the registered ovf_o / zero_o flags.
module csa_addsub_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
`ifdef CSA_FLAGS_EN
    output logic             ovf_o,
    output logic             zero_o,
`endif
    output logic             cout_o
);

    localparam int W_S = WIDTH / STAGES;
    localparam int NC  = W_S / BLOCK;

    if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_cfg_err
        $error("csa_addsub_pipe: WIDTH must be a multiple of STAGES*BLOCK");
    end

    // Handshake: a beat moves on a clock edge when valid && ready on that interface;
    // a stage loads whenever it is empty or its own contents are moving on.
    logic             adv   [STAGES];
    logic             v_s   [STAGES];
    logic             c_s   [STAGES];
    logic [WIDTH-1:0] sum_s [STAGES];
    logic [WIDTH-1:0] a_s   [STAGES];
    logic [WIDTH-1:0] b_s   [STAGES];

`ifdef CSA_FLAGS_EN
    logic ovf_q;
    logic zero_q;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [W_S-1:0]   op_a;
        logic [W_S-1:0]   op_b;
        logic [W_S-1:0]   slice;
        logic             cc [NC+1];
        logic [WIDTH-1:0] s_nx;
        logic             v_r;
        logic             c_r;
        logic [WIDTH-1:0] s_r;

        if (k == 0) begin : g_first
            assign a_in = a_i;
            assign b_in = (sub_i == OP_SUB) ? ~b_i : b_i;
            assign s_in = '0;
            assign c_in = (sub_i == OP_ADD) ? 1'b0 : 1'b1;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = a_s[k-1];
            assign b_in = b_s[k-1];
            assign s_in = sum_s[k-1];
            assign c_in = c_s[k-1];
            assign v_in = v_s[k-1];
        end

        assign op_a  = W_S'(a_in >> (k * W_S));
        assign op_b  = W_S'(b_in >> (k * W_S));
        assign cc[0] = c_in;

        for (genvar j = 0; j < NC; j++) begin : g_cell
            csa_cell #(.BLOCK(BLOCK)) u_cell (
                .a    (op_a[j*BLOCK +: BLOCK]),
                .b    (op_b[j*BLOCK +: BLOCK]),
                .cin  (cc[j]),
                .sum  (slice[j*BLOCK +: BLOCK]),
                .cout (cc[j+1])
            );
        end

        always_comb begin
            s_nx = s_in;
            s_nx[k*W_S +: W_S] = slice;
        end

        if (k == STAGES - 1) begin : g_adv_last
            assign adv[k] = !v_r || out_ready;
        end else begin : g_adv_mid
            assign adv[k] = !v_r || adv[k+1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (adv[k]) begin
                v_r <= v_in;
                c_r <= cc[NC];
                s_r <= s_nx;
            end
        end

        assign v_s[k]   = v_r;
        assign c_s[k]   = c_r;
        assign sum_s[k] = s_r;

        if (k < STAGES - 1) begin : g_fwd
            // Operands ride along so later stages can finish the upper slices.
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv[k]) begin
                    a_r <= a_in;
                    b_r <= b_in;
                end
            end

            assign a_s[k] = a_r;
            assign b_s[k] = b_r;
        end else begin : g_last
            assign a_s[k] = '0;
            assign b_s[k] = '0;
`ifdef CSA_FLAGS_EN
            // b_in is already inverted for subtraction, so its sign is sB'.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv[k]) begin
                    ovf_q  <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_nx[WIDTH-1] != a_in[WIDTH-1]);
                    zero_q <= (s_nx == '0);
                end
            end
`endif
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_s[STAGES-1];
    assign sum_o     = sum_s[STAGES-1];
    assign cout_o    = c_s[STAGES-1];

`ifdef CSA_FLAGS_EN
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;
`endif

endmodule
